// File: rtl/sobel_pkg.sv
// Shared constants for the Sobel frame sequencer: frame defaults,
// FSM state encoding and the window byte-lane helper.
package sobel_pkg;

  localparam int IMG_W_DEF  = 640;
  localparam int IMG_H_DEF  = 480;
  localparam int PIX_W_DEF  = 8;
  localparam int ADDR_W_DEF = 19;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PRIME = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_ISSUE = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_WRITE = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  // Last step of each read state is a capture-only cycle.
  localparam logic [2:0] PRIME_LAST = 3'd6;
  localparam logic [2:0] FETCH_LAST = 3'd3;

  function automatic int win_idx(input int i, input int j);
    return 3 * i + j;
  endfunction

endpackage

// File: rtl/sobel_window_regs.sv
// 3x3 pixel window with a left column shift and a single-pixel
// load port; presents the window as a flat byte-lane bus.
module sobel_window_regs
  import sobel_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               shift_col_i,
  input  logic               load_i,
  input  logic [1:0]         load_row_i,
  input  logic [1:0]         load_col_i,
  input  logic [PIX_W-1:0]   load_pix_i,
  output logic [9*PIX_W-1:0] win_o
);

  logic [PIX_W-1:0] px_q [3][3];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          px_q[i][j] <= '0;
        end
      end
    end else begin
      if (shift_col_i) begin
        for (int i = 0; i < 3; i++) begin
          px_q[i][0] <= px_q[i][1];
          px_q[i][1] <= px_q[i][2];
        end
      end
      if (load_i) begin
        px_q[load_row_i][load_col_i] <= load_pix_i;
      end
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_row
    for (genvar gj = 0; gj < 3; gj++) begin : g_col
      assign win_o[PIX_W*win_idx(gi, gj) +: PIX_W] = px_q[gi][gj];
    end
  end

endmodule

// File: rtl/sobel_frame_sequencer.sv
// Walks one frame through the Sobel core: column-sliding 3x3 window
// fetch, valid/ready hand-off, and linear result write-back.
module sobel_frame_sequencer
  import sobel_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int PIX_W  = PIX_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               mem_rd_en,
  output logic [ADDR_W-1:0]  mem_rd_addr,
  input  logic [PIX_W-1:0]   mem_rd_data,
  output logic               win_valid,
  input  logic               win_ready,
  output logic [9*PIX_W-1:0] win_data,
  input  logic               res_valid,
  input  logic [PIX_W-1:0]   res_data,
  output logic               out_wr_en,
  output logic [ADDR_W-1:0]  out_wr_addr,
  output logic [PIX_W-1:0]   out_wr_data
);

  localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;

  localparam logic [CW-1:0]     C_LAST = CW'(IMG_W - 3);
  localparam logic [RW-1:0]     R_LAST = RW'(IMG_H - 3);
  localparam logic [ADDR_W-1:0] W1_A   = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] W2_A   = ADDR_W'(2 * IMG_W);

  logic [2:0]        state_q, state_d;
  logic [2:0]        step_q, step_d;
  logic [CW-1:0]     c_q, c_d;
  logic [RW-1:0]     r_q, r_d;
  logic [ADDR_W-1:0] rbase_q, rbase_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [PIX_W-1:0]  res_q, res_d;

  logic              ld_q;
  logic [1:0]        ld_row_q;
  logic [1:0]        ld_col_q;

  logic              rd_en;
  logic [1:0]        rd_row;
  logic [1:0]        rd_col;
  logic [1:0]        wcol;
  logic [ADDR_W-1:0] roff;
  logic [ADDR_W-1:0] rd_addr;
  logic              shift_col;

  // PRIME walks cols c, c+1; FETCH walks col c+2. Rows go r..r+2.
  always_comb begin
    rd_en  = 1'b0;
    rd_row = 2'd0;
    rd_col = 2'd0;
    if (state_q == S_PRIME) begin
      unique case (step_q)
        3'd0:    begin rd_en = 1'b1; rd_row = 2'd0; rd_col = 2'd0; end
        3'd1:    begin rd_en = 1'b1; rd_row = 2'd1; rd_col = 2'd0; end
        3'd2:    begin rd_en = 1'b1; rd_row = 2'd2; rd_col = 2'd0; end
        3'd3:    begin rd_en = 1'b1; rd_row = 2'd0; rd_col = 2'd1; end
        3'd4:    begin rd_en = 1'b1; rd_row = 2'd1; rd_col = 2'd1; end
        3'd5:    begin rd_en = 1'b1; rd_row = 2'd2; rd_col = 2'd1; end
        default: begin rd_en = 1'b0; end
      endcase
    end else if (state_q == S_FETCH && step_q != FETCH_LAST) begin
      rd_en  = 1'b1;
      rd_row = step_q[1:0];
      rd_col = 2'd2;
    end
  end

  always_comb begin
    roff = '0;
    unique case (1'b1)
      rd_row == 2'd1: roff = W1_A;
      rd_row == 2'd2: roff = W2_A;
      default:        roff = '0;
    endcase
  end

  assign rd_addr   = rbase_q + roff + ADDR_W'(c_q) + ADDR_W'(rd_col);
  // Memory col c lands in window col 1 so the FETCH shift moves it to 0.
  assign wcol      = (rd_col == 2'd0) ? 2'd1 : 2'd2;
  assign shift_col = (state_q == S_FETCH) && (step_q == 3'd0);

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    c_d     = c_q;
    r_d     = r_q;
    rbase_d = rbase_q;
    idx_d   = idx_q;
    res_d   = res_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_PRIME;
          step_d  = 3'd0;
          c_d     = '0;
          r_d     = '0;
          rbase_d = '0;
          idx_d   = '0;
        end
      end
      S_PRIME: begin
        if (step_q == PRIME_LAST) begin
          state_d = S_FETCH;
          step_d  = 3'd0;
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      S_FETCH: begin
        if (step_q == FETCH_LAST) begin
          state_d = S_ISSUE;
          step_d  = 3'd0;
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      S_ISSUE: begin
        if (win_ready) begin
          if (res_valid) begin
            res_d   = res_data;
            state_d = S_WRITE;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (res_valid) begin
          res_d   = res_data;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        idx_d  = idx_q + ADDR_W'(1);
        step_d = 3'd0;
        if (c_q < C_LAST) begin
          c_d     = c_q + CW'(1);
          state_d = S_FETCH;
        end else if (r_q < R_LAST) begin
          c_d     = '0;
          r_d     = r_q + RW'(1);
          rbase_d = rbase_q + W1_A;
          state_d = S_PRIME;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      step_q   <= 3'd0;
      c_q      <= '0;
      r_q      <= '0;
      rbase_q  <= '0;
      idx_q    <= '0;
      res_q    <= '0;
      ld_q     <= 1'b0;
      ld_row_q <= 2'd0;
      ld_col_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      c_q      <= c_d;
      r_q      <= r_d;
      rbase_q  <= rbase_d;
      idx_q    <= idx_d;
      res_q    <= res_d;
      ld_q     <= rd_en;
      ld_row_q <= rd_row;
      ld_col_q <= wcol;
    end
  end

  sobel_window_regs #(
    .PIX_W (PIX_W)
  ) u_win (
    .clk         (clk),
    .reset       (reset),
    .shift_col_i (shift_col),
    .load_i      (ld_q),
    .load_row_i  (ld_row_q),
    .load_col_i  (ld_col_q),
    .load_pix_i  (mem_rd_data),
    .win_o       (win_data)
  );

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign win_valid   = (state_q == S_ISSUE);
  assign out_wr_en   = (state_q == S_WRITE);
  assign out_wr_addr = idx_q;
  assign out_wr_data = res_q;
  assign mem_rd_en   = rd_en;
  assign mem_rd_addr = rd_en ? rd_addr : '0;

endmodule
